io_output_sink: RTL

//  Receiving end of the CPU IO path. Drives the CPU start level (startIO) and captures

---
 rtl/io_sink_pkg.sv | 14 +
 rtl/io_output_sink_if.sv | 22 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/io_output_sink.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/io_sink_pkg.sv
// Shared types and constants for the CPU IO output sink.
package io_sink_pkg;

   // Run lifecycle of the sink.
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } sink_state_t;

   localparam int unsigned CHECKSUMWIDTH = 32;

endpackage

// File: rtl/io_output_sink_if.sv
// Downstream valid/ready word stream from the sink to its consumer.
interface io_output_sink_if #(
   parameter int unsigned DATAWIDTH = 25
);

   logic                 mValid;
   logic [DATAWIDTH-1:0] mData;
   logic                 mReady;

   modport master (
      output mValid,
      output mData,
      input  mReady
   );

   modport slave (
      input  mValid,
      input  mData,
      output mReady
   );

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO. A push while full is accepted when a pop
// happens in the same cycle. The head reads as zero while empty so the
// downstream data bus is deterministic after reset.
module sync_fifo #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned DEPTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic [WIDTH-1:0]        pushData,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PtrWidth = $clog2(DEPTH);
   localparam int unsigned CntWidth = PtrWidth + 1;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [PtrWidth-1:0] wrPtrQ;
   logic [PtrWidth-1:0] rdPtrQ;
   logic [CntWidth-1:0] countQ;
   logic                doPush;
   logic                doPop;

   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         if (doPush) begin
            wrPtrQ <= wrPtrQ + PtrWidth'(1);
         end
         if (doPop) begin
            rdPtrQ <= rdPtrQ + PtrWidth'(1);
         end
         if (doPush && !doPop) begin
            countQ <= countQ + CntWidth'(1);
         end else if (doPop && !doPush) begin
            countQ <= countQ - CntWidth'(1);
         end
      end
   end

   // Storage needs no reset; occupancy decides what is visible.
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem[wrPtrQ] <= pushData;
      end
   end

   assign full  = (countQ == CntWidth'(DEPTH));
   assign empty = (countQ == '0);
   assign head  = empty ? '0 : mem[rdPtrQ];
   assign count = countQ;

endmodule

// File: rtl/io_output_sink.sv
// Receiving end of the CPU IO path: raises the CPU start level, captures each
// write-back IO word into a FIFO and drains it to a downstream consumer.
// Optional feature macro: IO_SINK_CHECKSUM_EN (running 32-bit sum of accepted
// words); when undefined the checksum output is tied to zero.
module io_output_sink
   import io_sink_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 25,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned CNTWIDTH  = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     startReq,
   input  logic [CNTWIDTH-1:0]      wordTarget,
   input  logic                     outFlagIO,
   input  logic [DATAWIDTH-1:0]     outData,
   output logic                     startIO,
   io_output_sink_if.master         sinkBus,
   output logic [CNTWIDTH-1:0]      captured,
   output logic                     overflow,
   output logic                     done,
   output logic [CHECKSUMWIDTH-1:0] checksum
);

   localparam int unsigned OccWidth = $clog2(DEPTH) + 1;
   localparam int unsigned SumWidth = CNTWIDTH + 1;

   sink_state_t          stateQ;
   sink_state_t          stateD;
   logic                 startIOQ;
   logic                 doneQ;
   logic [CNTWIDTH-1:0]  capturedQ;
   logic                 overflowQ;

   logic                 fifoPush;
   logic                 fifoPop;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [DATAWIDTH-1:0] fifoHead;
   logic [OccWidth-1:0]  fifoCount;

   logic                 inRun;
   logic                 startRun;
   logic                 dropped;
   logic [SumWidth-1:0]  capturedSum;
   logic                 targetHit;
   logic                 drainEmpty;

   // Draining runs in every state; only reset empties the FIFO otherwise.
   assign fifoPop  = !fifoEmpty && sinkBus.mReady;
   assign inRun    = (stateQ == RUN);
   assign fifoPush = inRun && outFlagIO && (!fifoFull || fifoPop);
   assign dropped  = inRun && outFlagIO && !fifoPush;
   assign startRun = (stateQ == IDLE) && startReq;

   // One extra bit so the compare against the target never wraps.
   assign capturedSum = SumWidth'(capturedQ) + SumWidth'(fifoPush);
   assign targetHit   = (wordTarget != '0) && (capturedSum == SumWidth'(wordTarget));

   // Empty now, or the last word leaves on this edge.
   assign drainEmpty = fifoEmpty || (fifoPop && (fifoCount == OccWidth'(1)));

   sync_fifo #(
      .WIDTH (DATAWIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifoPush),
      .pushData (outData),
      .pop      (fifoPop),
      .head     (fifoHead),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   // Next-state decode for the run lifecycle.
   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         IDLE: begin
            if (startReq) begin
               stateD = RUN;
            end
         end
         RUN: begin
            if (targetHit || !startReq) begin
               stateD = DRAIN;
            end
         end
         DRAIN: begin
            if (drainEmpty) begin
               stateD = DONE;
            end
         end
         DONE: begin
            if (!startReq) begin
               stateD = IDLE;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   // State register plus registered startIO/done levels derived from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ   <= IDLE;
         startIOQ <= 1'b0;
         doneQ    <= 1'b0;
      end else begin
         stateQ   <= stateD;
         startIOQ <= (stateD == RUN);
         doneQ    <= (stateD == DONE);
      end
   end

   // Accepted-word counter, cleared at the start of each run, saturating.
   always_ff @(posedge clock) begin
      if (reset || startRun) begin
         capturedQ <= '0;
      end else if (fifoPush && (capturedQ != {CNTWIDTH{1'b1}})) begin
         capturedQ <= capturedQ + CNTWIDTH'(1);
      end
   end

   // Sticky flag for strobes lost to a full FIFO during the current run.
   always_ff @(posedge clock) begin
      if (reset || startRun) begin
         overflowQ <= 1'b0;
      end else if (dropped) begin
         overflowQ <= 1'b1;
      end
   end

`ifdef IO_SINK_CHECKSUM_EN
   logic [CHECKSUMWIDTH-1:0] checksumQ;

   // Running modular sum of accepted words.
   always_ff @(posedge clock) begin
      if (reset || startRun) begin
         checksumQ <= '0;
      end else if (fifoPush) begin
         checksumQ <= checksumQ + CHECKSUMWIDTH'(outData);
      end
   end

   assign checksum = checksumQ;
`else
   assign checksum = '0;
`endif

   assign startIO        = startIOQ;
   assign done           = doneQ;
   assign captured       = capturedQ;
   assign overflow       = overflowQ;
   assign sinkBus.mValid = !fifoEmpty;
   assign sinkBus.mData  = fifoHead;

endmodule
